// File: rtl/uart_frame_decoder_if.sv
// Byte stream in from uart_rx and payload stream out to the consumer, bundled for the decoder.
// master drives received bytes and accepts payload; slave is the decoder side.
interface uart_frame_decoder_if;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       data_valid;
  logic [7:0] data_byte;
  logic       data_last;
  logic       data_ready;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_dv, rx_byte, data_ready,
    input  data_valid, data_byte, data_last, frame_ok, frame_err, overrun, busy
  );

  modport slave (
    input  rx_dv, rx_byte, data_ready,
    output data_valid, data_byte, data_last, frame_ok, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Parses SOF/LEN/payload/CHK frames, buffers the payload, and releases it on a good checksum.
// Status pulses one cycle after the deciding byte; payload drains valid/ready, and bytes received while draining are dropped.
module uart_frame_decoder #(
  parameter logic [7:0] SOF_BYTE = 8'h55,
  parameter int         MAX_LEN  = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Data_Byte,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Frame_Ok,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, GET_LEN, GET_PAYLOAD, GET_CHK, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    len, chk;
  logic [IW-1:0] wr_idx, rd_idx, rd_nxt;
  logic [7:0]    mem [MAX_LEN];

  logic len_bad, pay_last, rd_last, chk_match, xfer;
  logic ok_set, err_set, ovr_set;

  assign len_bad   = (i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B);
  assign pay_last  = (8'(wr_idx) == len - 8'd1);
  assign rd_last   = (8'(rd_idx) == len - 8'd1);
  assign chk_match = (chk == i_Rx_Byte);
  assign xfer      = o_Data_Valid && i_Data_Ready;
  assign rd_nxt    = rd_idx + 1'b1;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) state_nxt = GET_LEN;
      GET_LEN:     if (i_Rx_DV) state_nxt = len_bad ? IDLE : GET_PAYLOAD;
      GET_PAYLOAD: if (i_Rx_DV && pay_last) state_nxt = GET_CHK;
      GET_CHK:     if (i_Rx_DV) state_nxt = chk_match ? DRAIN : IDLE;
      DRAIN:       if (xfer && rd_last) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_Busy  = (state != IDLE);
    ok_set  = 1'b0;
    err_set = 1'b0;
    ovr_set = 1'b0;
    case (state)
      GET_LEN: err_set = i_Rx_DV && len_bad;
      GET_CHK: begin
        ok_set  = i_Rx_DV && chk_match;
        err_set = i_Rx_DV && !chk_match;
      end
      DRAIN:   ovr_set = i_Rx_DV;
      default: ;
    endcase
  end

  // Payload storage carries no reset; stale contents are never presented.
  always_ff @(posedge i_Clock) begin
    if (state == GET_PAYLOAD && i_Rx_DV) mem[wr_idx] <= i_Rx_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      len          <= 8'd0;
      chk          <= 8'd0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      o_Data_Valid <= 1'b0;
      o_Data_Byte  <= 8'd0;
      o_Data_Last  <= 1'b0;
      o_Frame_Ok   <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      o_Frame_Ok  <= ok_set;
      o_Frame_Err <= err_set;
      o_Overrun   <= ovr_set;
      case (state)
        GET_LEN: if (i_Rx_DV && !len_bad) begin
          len    <= i_Rx_Byte;
          chk    <= i_Rx_Byte;
          wr_idx <= '0;
        end
        GET_PAYLOAD: if (i_Rx_DV) begin
          chk <= chk ^ i_Rx_Byte;
          if (!pay_last) wr_idx <= wr_idx + 1'b1;
        end
        GET_CHK: if (i_Rx_DV && chk_match) begin
          o_Data_Valid <= 1'b1;
          o_Data_Byte  <= mem['0];
          o_Data_Last  <= (len == 8'd1);
          rd_idx       <= '0;
        end
        DRAIN: if (xfer) begin
          if (rd_last) begin
            o_Data_Valid <= 1'b0;
            o_Data_Last  <= 1'b0;
          end else begin
            rd_idx      <= rd_nxt;
            o_Data_Byte <= mem[rd_nxt];
            o_Data_Last <= (8'(rd_idx) + 8'd2 == len);
          end
        end
        default: wr_idx <= '0;
      endcase
    end
  end

endmodule
